// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clock out frame, check device ACK.
// Optional build macro PS2_TX_RETRY_EN enables automatic re-send on NACK/timeout (up to MAX_RETRY extra).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int RTS_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clock50,
  input  logic       resetN,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  input  logic       keyboardClock,
  input  logic       keyboardData,
  output logic       keyboardClockOe,
  output logic       keyboardDataOe,
  output logic       txBusy,
  output logic       txDone,
  output logic       txError
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_RTS       = 3'd2,
    S_SEND      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_DONE      = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  localparam int CntMaxA = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CntMax  = (CntMaxA > TIMEOUT_CYCLES) ? CntMaxA : TIMEOUT_CYCLES;
  localparam int CntW    = $clog2(CntMax + 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      shift_q, shift_d;
  logic            clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic            clock_oe_q, clock_oe_d, data_oe_q, data_oe_d;
  logic            busy_q, busy_d, done_q, done_d, error_q, error_d, ready_q, ready_d;
  logic            fall_s, accept_s, timeout_s, fail_s;

`ifdef PS2_TX_RETRY_EN
  localparam int RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RetryW-1:0] retry_q, retry_d;
`else
  logic unused_retry_s;
  assign unused_retry_s = (MAX_RETRY > 0);
`endif

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  assign fall_s    = clk_prev_q & ~clk_s2_q;
  assign accept_s  = txValid & ready_q;
  assign timeout_s = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  assign txReady         = ready_q;
  assign txBusy          = busy_q;
  assign txDone          = done_q;
  assign txError         = error_q;
  assign keyboardClockOe = clock_oe_q;
  assign keyboardDataOe  = data_oe_q;

  // State, datapath, synchroniser and registered-output flops
  always_ff @(posedge clock50) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 10'd0;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      clock_oe_q <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      ready_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      clk_s1_q   <= keyboardClock;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= keyboardData;
      dat_s2_q   <= dat_s1_q;
      clock_oe_q <= clock_oe_d;
      data_oe_q  <= data_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      ready_q    <= ready_d;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  // Next-state, phase counter, bit counter and shift register
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    fail_s    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_INHIBIT;
          cnt_d   = '0;
          shift_d = {1'b1, odd_parity(txData), txData};
`ifdef PS2_TX_RETRY_EN
          retry_d = '0;
`endif
        end else begin
          cnt_d = '0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
          state_d = S_RTS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_RTS: begin
        if (cnt_q == CntW'(RTS_CYCLES - 1)) begin
          state_d   = S_SEND;
          cnt_d     = '0;
          bit_cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_SEND: begin
        if (fall_s) begin
          cnt_d     = '0;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end else begin
            state_d = S_SEND;
          end
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_ACK: begin
        if (fall_s) begin
          cnt_d = '0;
          if (dat_s2_q) begin
            fail_s = 1'b1;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          state_d = S_DONE;
        end else if (fall_s) begin
          cnt_d = '0;
        end else if (timeout_s) begin
          fail_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAIL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A failed attempt either restarts the whole handshake with the latched byte or gives up
    if (fail_s) begin
      cnt_d = '0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q < RetryW'(MAX_RETRY)) begin
        state_d = S_INHIBIT;
        retry_d = retry_q + RetryW'(1);
      end else begin
        state_d = S_FAIL;
      end
`else
      state_d = S_FAIL;
`endif
    end else begin
      cnt_d = cnt_d;
    end
  end

  // Output decode from the upcoming state, so every output is a flop
  always_comb begin
    clock_oe_d = 1'b0;
    data_oe_d  = 1'b0;
    busy_d     = 1'b1;
    done_d     = 1'b0;
    error_d    = 1'b0;
    ready_d    = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      S_INHIBIT: clock_oe_d = 1'b1;
      S_RTS: begin
        clock_oe_d = 1'b1;
        data_oe_d  = 1'b1;
      end
      S_SEND: begin
        if (state_q != S_SEND) begin
          data_oe_d = 1'b1;
        end else if (fall_s) begin
          data_oe_d = ~shift_q[bit_cnt_q];
        end else begin
          data_oe_d = data_oe_q;
        end
      end
      S_ACK:       data_oe_d = 1'b0;
      S_WAIT_IDLE: data_oe_d = 1'b0;
      S_DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      S_FAIL: begin
        busy_d  = 1'b0;
        error_d = 1'b1;
      end
      default: busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 device on wired-AND lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int I = 40;
  localparam int R = 8;
  localparam int T = 200;
  localparam int H = 10;
  localparam int PH_OFF = 0;
  localparam int PH_IDLE = 1;
  localparam int PH_FRAME = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN, txValid, txReady, busy, done, err, clock_oe, data_oe;
  logic [7:0] txData;
  logic       dev_clk, dev_data, kb_clk, kb_data;
  assign kb_clk  = dev_clk & ~clock_oe;
  assign kb_data = dev_data & ~data_oe;

  int cyc, acc_cyc, ph, checks, failures, done_cnt, err_cnt, inh_cnt, err_cyc;
  logic [1:0] err_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(I), .RTS_CYCLES(R), .TIMEOUT_CYCLES(T), .MAX_RETRY(2)) dut (
    .clock50(clk), .resetN(resetN), .txData(txData), .txValid(txValid), .txReady(txReady),
    .keyboardClock(kb_clk), .keyboardData(kb_data),
    .keyboardClockOe(clock_oe), .keyboardDataOe(data_oe),
    .txBusy(busy), .txDone(done), .txError(err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected frame from the protocol rule: LSB-first data, odd parity, stop 1
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic compare_loop();
    logic prev_coe;
    int   t;
    prev_coe = 1'b0;
    forever begin
      @(negedge clk);
      t = cyc - acc_cyc + 1;
      if (done && err) chk("done_error_exclusive", {done, err}, 2'b00);
      if (done) done_cnt++;
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
        err_oe  = {clock_oe, data_oe};
      end
      if (clock_oe && !prev_coe) inh_cnt++;
      prev_coe = clock_oe;
      if (ph == PH_FRAME && t <= I + R + 1) begin
        chk("frame_clock_oe", clock_oe, (t <= I + R) ? 1 : 0);
        chk("frame_data_oe", data_oe, (t > I) ? 1 : 0);
        chk("frame_busy", busy, 1);
        chk("frame_ready", txReady, 0);
        chk("frame_pulses", {done, err}, 2'b00);
      end else if (ph == PH_IDLE) begin
        chk("idle_oe", {clock_oe, data_oe}, 2'b00);
        chk("idle_busy", busy, 0);
        chk("idle_ready", txReady, 1);
        chk("idle_pulses", {done, err}, 2'b00);
      end
    end
  endtask

  task automatic device_xfer(input logic nack, input int stop_after,
                             output logic [9:0] cap, output logic sb, output int lf);
    int n;
    cap = 10'bx;
    lf  = 0;
    n = 0;
    while (clock_oe !== 1'b1 && n < I + R + 50) begin tick(); n++; end
    chk("wait_inhibit", clock_oe, 1);
    n = 0;
    while (clock_oe !== 1'b0 && n < I + R + 50) begin tick(); n++; end
    chk("wait_release", clock_oe, 0);
    repeat (H) tick();
    sb = kb_data;
    for (int k = 1; k <= 11; k++) begin
      if (k <= stop_after) begin
        if (k == 11) dev_data = nack;
        dev_clk = 1'b0;
        lf = cyc;
        repeat (H) tick();
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        if (k <= 10) cap[k-1] = kb_data;
        repeat (H) tick();
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input int attempts, input int nacks,
                           input int stop_after, input logic do_rst,
                           output logic [9:0] cap, output logic sb, output int lf);
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    tick();
    chk("accept_ready", txReady, 1);
    txData  = b;
    txValid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    ph = PH_FRAME;
    txData = 8'h55;
    repeat (10) tick();
    txValid = 1'b0;
    for (int a = 0; a < attempts; a++) device_xfer(a < nacks, stop_after, cap, sb, lf);
    if (do_rst) begin
      resetN = 1'b0;
      ph = PH_OFF;
      tick();
      chk("midreset_oe", {clock_oe, data_oe}, 2'b00);
      chk("midreset_busy", busy, 0);
      chk("midreset_ready", txReady, 0);
      chk("midreset_pulses", {done, err}, 2'b00);
      resetN = 1'b1;
      tick();
      chk("midreset_ready_back", txReady, 1);
      ph = PH_IDLE;
      repeat (T + 20) tick();
      chk("midreset_no_done", done_cnt, d0);
      chk("midreset_no_error", err_cnt, e0);
    end else begin
      n = 0;
      while (done_cnt == d0 && err_cnt == e0 && n < 2 * T + 100) begin tick(); n++; end
      chk("frame_end_seen", (done_cnt != d0 || err_cnt != e0) ? 1 : 0, 1);
      ph = PH_IDLE;
    end
  endtask

  logic [9:0] lit_tab [3];
  logic [7:0] byte_tab [3];

  initial begin
    logic [9:0] cap;
    logic       sb;
    int         lf, d0, e0, i0;
    resetN = 1'b0; txValid = 1'b0; txData = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1; ph = PH_OFF;
    fork compare_loop(); join_none
    repeat (3) tick();
    chk("reset_oe", {clock_oe, data_oe}, 2'b00);
    chk("reset_ready", txReady, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pulses", {done, err}, 2'b00);
    resetN = 1'b1;
    tick();
    chk("ready_after_reset", txReady, 1);
    ph = PH_IDLE;

    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    run_frame(8'hED, 1, 0, 11, 1'b0, cap, sb, lf);
    chk("ed_frame_literal", cap, 10'b11_1110_1101);
    chk("ed_frame_model", cap, model_frame(8'hED));
    chk("ed_start_bit", sb, 0);
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_error", err_cnt - e0, 0);
    chk("ed_inhibits", inh_cnt - i0, 1);

    byte_tab[0] = 8'h07; lit_tab[0] = 10'b10_0000_0111;
    byte_tab[1] = 8'hFF; lit_tab[1] = 10'b11_1111_1111;
    byte_tab[2] = 8'h00; lit_tab[2] = 10'b11_0000_0000;
    for (int k = 0; k < 3; k++) begin
      d0 = done_cnt; e0 = err_cnt;
      run_frame(byte_tab[k], 1, 0, 11, 1'b0, cap, sb, lf);
      chk("tab_frame_literal", cap, lit_tab[k]);
      chk("tab_frame_model", cap, model_frame(byte_tab[k]));
      chk("tab_done", done_cnt - d0, 1);
      chk("tab_error", err_cnt - e0, 0);
    end

`ifndef PS2_TX_RETRY_EN
    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'h3C, 1, 1, 11, 1'b0, cap, sb, lf);
    chk("nack_error", err_cnt - e0, 1);
    chk("nack_done", done_cnt - d0, 0);
    chk("nack_frame_model", cap, model_frame(8'h3C));
    tick();
    chk("nack_ready_back", txReady, 1);

    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'hA5, 1, 0, 4, 1'b0, cap, sb, lf);
    chk("timeout_error", err_cnt - e0, 1);
    chk("timeout_done", done_cnt - d0, 0);
    chk("timeout_latency", err_cyc - lf, T + 3);
    chk("timeout_oe", err_oe, 2'b00);
`else
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    run_frame(8'h96, 3, 2, 11, 1'b0, cap, sb, lf);
    chk("retry_ok_done", done_cnt - d0, 1);
    chk("retry_ok_error", err_cnt - e0, 0);
    chk("retry_ok_inhibits", inh_cnt - i0, 3);
    chk("retry_ok_frame", cap, model_frame(8'h96));

    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    run_frame(8'h69, 3, 3, 11, 1'b0, cap, sb, lf);
    chk("retry_fail_error", err_cnt - e0, 1);
    chk("retry_fail_done", done_cnt - d0, 0);
    chk("retry_fail_inhibits", inh_cnt - i0, 3);
`endif

    run_frame(8'h5A, 1, 0, 5, 1'b1, cap, sb, lf);
    d0 = done_cnt; e0 = err_cnt;
    run_frame(8'hC3, 1, 0, 11, 1'b0, cap, sb, lf);
    chk("post_reset_frame", cap, model_frame(8'hC3));
    chk("post_reset_done", done_cnt - d0, 1);
    chk("post_reset_error", err_cnt - e0, 0);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
